// File: rtl/toysram_16x12_ctl_if.sv
// toysram_16x12_ctl_if
//   Host-side bundle for the 16x12 toy SRAM controller: two read ports and
//   one write port.
//   rdX_req/rdX_addr   : read request and row address (host -> controller)
//   rdX_ack            : read accepted this cycle (controller -> host)
//   rdX_vld/rdX_data   : read data valid pulse and held read data
//   wr_req/wr_addr/wr_data : write request, row address, row data
//   wr_ack             : write accepted this cycle
//   wr_busy            : write sequence in progress
//   Modports: master (host side), slave (controller side).
interface toysram_16x12_ctl_if;
  logic        rd0_req;
  logic [3:0]  rd0_addr;
  logic        rd0_ack;
  logic        rd0_vld;
  logic [0:11] rd0_data;

  logic        rd1_req;
  logic [3:0]  rd1_addr;
  logic        rd1_ack;
  logic        rd1_vld;
  logic [0:11] rd1_data;

  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [0:11] wr_data;
  logic        wr_ack;
  logic        wr_busy;

  modport master (
    output rd0_req, rd0_addr, input rd0_ack, rd0_vld, rd0_data,
    output rd1_req, rd1_addr, input rd1_ack, rd1_vld, rd1_data,
    output wr_req, wr_addr, wr_data, input wr_ack, wr_busy
  );

  modport slave (
    input rd0_req, rd0_addr, output rd0_ack, rd0_vld, rd0_data,
    input rd1_req, rd1_addr, output rd1_ack, rd1_vld, rd1_data,
    input wr_req, wr_addr, wr_data, output wr_ack, wr_busy
  );
endinterface

// File: rtl/toysram_16x12_ctl.sv
// toysram_16x12_ctl
//   Controller for a 16-row x 12-bit toy SRAM macro with two pipelined read
//   ports and one sequenced write port.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : host-side handshake bundle (toysram_16x12_ctl_if.slave)
//   RWL0, RWL1 : read wordlines, one per read port (zero or one-hot)
//   WWL        : write wordline (one-hot only during the write pulse)
//   RBL0, RBL1 : read bitlines returned by the array
//   WBL, WBLb  : write bitlines, true and complement
//   Address i selects wordline bit [i]; data bit [k] maps to bitline bit [k].
//   Every array-side output comes straight from a flop.
//   Optional macro TOYSRAM_CTL_WR_BYPASS_EN: reads hitting the row of an
//   in-flight write are acked at once and return the latched write data
//   instead of stalling until the write sequence completes.
module toysram_16x12_ctl (
  input  logic                clk,
  input  logic                rst_n,
  toysram_16x12_ctl_if.slave  bus,
  output logic [0:15]         RWL0,
  output logic [0:15]         RWL1,
  output logic [0:15]         WWL,
  input  logic [0:11]         RBL0,
  input  logic [0:11]         RBL1,
  output logic [0:11]         WBL,
  output logic [0:11]         WBLb
);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_e;

  wr_state_e   wr_state_q, wr_state_d;
  logic [3:0]  wr_addr_q,  wr_addr_d;
  logic [0:11] wr_data_q,  wr_data_d;
  logic [0:15] rwl0_q, rwl0_d, rwl1_q, rwl1_d, wwl_q, wwl_d;
  logic [0:11] wbl_q, wbl_d, wblb_q, wblb_d;
  logic        rd0_p1_q, rd0_p1_d, rd1_p1_q, rd1_p1_d;
  logic        rd0_byp_q, rd0_byp_d, rd1_byp_q, rd1_byp_d;
  logic        rd0_vld_q, rd0_vld_d, rd1_vld_q, rd1_vld_d;
  logic [0:11] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;

  logic wr_acc, wr_busy;
  logic rd0_hit, rd1_hit, rd0_acc, rd1_acc, rd0_byp, rd1_byp;

  function automatic logic [0:15] row_sel(input logic [3:0] a);
    logic [0:15] s;
    s    = '0;
    s[a] = 1'b1;
    return s;
  endfunction

  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    wr_busy = (wr_state_q != W_IDLE);
    wr_acc  = bus.wr_req && (wr_state_q == W_IDLE);

    case (wr_state_q)
      W_IDLE: begin
        if (wr_acc) begin
          wr_state_d = W_SETUP;
          wr_addr_d  = bus.wr_addr;
          wr_data_d  = bus.wr_data;
        end
      end
      W_SETUP: wr_state_d = W_PULSE;
      W_PULSE: wr_state_d = W_HOLD;
      W_HOLD:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase

    // Array-side write drive is computed from the next state so the
    // bitlines/wordline flops line up with the state they belong to.
    wbl_d  = (wr_state_d != W_IDLE) ? wr_data_d  : '0;
    wblb_d = (wr_state_d != W_IDLE) ? ~wr_data_d : '0;
    wwl_d  = (wr_state_d == W_PULSE) ? row_sel(wr_addr_d) : '0;

    // A read only conflicts with a write that has left W_IDLE; a read
    // accepted alongside the write itself sees the old row.
    rd0_hit = wr_busy && (wr_addr_q == bus.rd0_addr);
    rd1_hit = wr_busy && (wr_addr_q == bus.rd1_addr);
`ifdef TOYSRAM_CTL_WR_BYPASS_EN
    rd0_acc = bus.rd0_req;
    rd1_acc = bus.rd1_req;
    rd0_byp = rd0_hit;
    rd1_byp = rd1_hit;
`else
    rd0_acc = bus.rd0_req && !rd0_hit;
    rd1_acc = bus.rd1_req && !rd1_hit;
    rd0_byp = 1'b0;
    rd1_byp = 1'b0;
`endif

    rwl0_d    = (rd0_acc && !rd0_byp) ? row_sel(bus.rd0_addr) : '0;
    rwl1_d    = (rd1_acc && !rd1_byp) ? row_sel(bus.rd1_addr) : '0;
    rd0_p1_d  = rd0_acc;
    rd1_p1_d  = rd1_acc;
    rd0_byp_d = rd0_byp;
    rd1_byp_d = rd1_byp;

    // wr_data_q still holds the bypassed write's data here even if a new
    // write is accepted in this same cycle (it only lands at the edge).
    rd0_vld_d  = rd0_p1_q;
    rd1_vld_d  = rd1_p1_q;
    rd0_data_d = rd0_data_q;
    rd1_data_d = rd1_data_q;
    if (rd0_p1_q) rd0_data_d = rd0_byp_q ? wr_data_q : RBL0;
    if (rd1_p1_q) rd1_data_d = rd1_byp_q ? wr_data_q : RBL1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rwl0_q     <= '0;
      rwl1_q     <= '0;
      wwl_q      <= '0;
      wbl_q      <= '0;
      wblb_q     <= '0;
      rd0_p1_q   <= 1'b0;
      rd1_p1_q   <= 1'b0;
      rd0_byp_q  <= 1'b0;
      rd1_byp_q  <= 1'b0;
      rd0_vld_q  <= 1'b0;
      rd1_vld_q  <= 1'b0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rwl0_q     <= rwl0_d;
      rwl1_q     <= rwl1_d;
      wwl_q      <= wwl_d;
      wbl_q      <= wbl_d;
      wblb_q     <= wblb_d;
      rd0_p1_q   <= rd0_p1_d;
      rd1_p1_q   <= rd1_p1_d;
      rd0_byp_q  <= rd0_byp_d;
      rd1_byp_q  <= rd1_byp_d;
      rd0_vld_q  <= rd0_vld_d;
      rd1_vld_q  <= rd1_vld_d;
      rd0_data_q <= rd0_data_d;
      rd1_data_q <= rd1_data_d;
    end
  end

  assign RWL0 = rwl0_q;
  assign RWL1 = rwl1_q;
  assign WWL  = wwl_q;
  assign WBL  = wbl_q;
  assign WBLb = wblb_q;

  assign bus.rd0_ack  = rd0_acc;
  assign bus.rd1_ack  = rd1_acc;
  assign bus.rd0_vld  = rd0_vld_q;
  assign bus.rd1_vld  = rd1_vld_q;
  assign bus.rd0_data = rd0_data_q;
  assign bus.rd1_data = rd1_data_q;
  assign bus.wr_ack   = wr_acc;
  assign bus.wr_busy  = wr_busy;

endmodule

// File: tb/tb_toysram_16x12_ctl.sv
// tb_toysram_16x12_ctl
//   Directed bench for toysram_16x12_ctl with a behavioural 16x12 array
//   attached to the wordlines/bitlines. Honors TOYSRAM_CTL_WR_BYPASS_EN.
module tb_toysram_16x12_ctl;
  logic        clk;
  logic        rst_n;
  logic [0:15] RWL0, RWL1, WWL;
  logic [0:11] RBL0, RBL1, WBL, WBLb;

  toysram_16x12_ctl_if bus ();

  toysram_16x12_ctl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .RWL0 (RWL0),
    .RWL1 (RWL1),
    .WWL  (WWL),
    .RBL0 (RBL0),
    .RBL1 (RBL1),
    .WBL  (WBL),
    .WBLb (WBLb)
  );

  int errors = 0;
  int checks = 0;

  logic [0:11] mem    [16];
  logic [0:11] shadow [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array: a row takes WBL when its write wordline rises.
  always @(WWL) begin
    for (int i = 0; i < 16; i++) if (WWL[i]) mem[i] = WBL;
  end

  always_comb begin
    RBL0 = '0;
    RBL1 = '0;
    for (int i = 0; i < 16; i++) begin
      if (RWL0[i]) RBL0 = RBL0 | mem[i];
      if (RWL1[i]) RBL1 = RBL1 | mem[i];
    end
  end

  function automatic logic [0:15] oh(input logic [3:0] a);
    logic [0:15] s;
    s    = '0;
    s[a] = 1'b1;
    return s;
  endfunction

  function automatic logic [0:11] pat(input logic [3:0] n);
    return {n, ~n, n ^ 4'hA};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an idle cycle; returns in the cycle the FSM is idle again.
  task automatic do_write(input logic [3:0] a, input logic [0:11] d);
    int w;
    w = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    #1;
    while (!bus.wr_ack && w < 10) begin
      tick();
      #1;
      w++;
    end
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL write_accept_timeout: wr_ack=%0b required 1", bus.wr_ack);
    end
    tick();
    bus.wr_req = 1'b0;
    shadow[a]  = d;
    tick();
    tick();
    tick();
  endtask

  // Issues one read, waits for ack; returns in the vld cycle (accept+2).
  task automatic do_read(input int port, input logic [3:0] a, output int stalls,
                         output logic [0:15] rwl, output logic vld,
                         output logic [0:11] data);
    logic ack;
    stalls = 0;
    if (port == 0) begin bus.rd0_req = 1'b1; bus.rd0_addr = a; end
    else           begin bus.rd1_req = 1'b1; bus.rd1_addr = a; end
    #1;
    ack = (port == 0) ? bus.rd0_ack : bus.rd1_ack;
    while (!ack && stalls < 10) begin
      tick();
      #1;
      stalls++;
      ack = (port == 0) ? bus.rd0_ack : bus.rd1_ack;
    end
    tick();
    if (port == 0) bus.rd0_req = 1'b0; else bus.rd1_req = 1'b0;
    rwl = (port == 0) ? RWL0 : RWL1;
    tick();
    vld  = (port == 0) ? bus.rd0_vld  : bus.rd1_vld;
    data = (port == 0) ? bus.rd0_data : bus.rd1_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({RWL0, RWL1, WWL} !== '0) begin
      errors++;
      $display("FAIL reset_wordlines: got %h %h %h required 0", RWL0, RWL1, WWL);
    end
    checks++;
    if ({WBL, WBLb} !== '0) begin
      errors++;
      $display("FAIL reset_bitlines: got %h %h required 0", WBL, WBLb);
    end
    checks++;
    if ({bus.rd0_vld, bus.rd1_vld} !== 2'b00) begin
      errors++;
      $display("FAIL reset_vld: got %b%b required 00", bus.rd0_vld, bus.rd1_vld);
    end
    checks++;
    if ({bus.rd0_data, bus.rd1_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h required 0", bus.rd0_data, bus.rd1_data);
    end
    checks++;
    if (bus.wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", bus.wr_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    do_write(4'd5, 12'hA5C);
    do_read(0, 4'd5, st, rwl, vld, dat);
    checks++;
    if (st != 0) begin errors++; $display("FAIL basic_stall: got %0d required 0", st); end
    checks++;
    if (rwl !== oh(4'd5)) begin errors++; $display("FAIL basic_rwl: got %h required %h", rwl, oh(4'd5)); end
    checks++;
    if (RWL0 !== '0) begin errors++; $display("FAIL basic_rwl_one_cycle: got %h required 0", RWL0); end
    checks++;
    if (vld !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b required 1", vld); end
    checks++;
    if (dat !== 12'hA5C) begin errors++; $display("FAIL basic_data: got %h required a5c", dat); end
    tick();
    checks++;
    if (bus.rd0_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_pulse: got %b required 0", bus.rd0_vld); end
    checks++;
    if (bus.rd0_data !== 12'hA5C) begin errors++; $display("FAIL basic_data_hold: got %h required a5c", bus.rd0_data); end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    logic [0:15] e0, e1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 16; i++) do_write(4'(i), pat(4'(i)));
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin
        bus.rd0_req = 1'b1; bus.rd0_addr = 4'(c);
        bus.rd1_req = 1'b1; bus.rd1_addr = 4'(15 - c);
      end else begin
        bus.rd0_req = 1'b0;
        bus.rd1_req = 1'b0;
      end
      #1;
      if (c < 16) begin
        checks++;
        if ({bus.rd0_ack, bus.rd1_ack} !== 2'b11) begin
          errors++;
          $display("FAIL b2b_ack c=%0d: got %b%b required 11", c, bus.rd0_ack, bus.rd1_ack);
        end
      end
      e0 = (c >= 1 && c <= 16) ? oh(4'(c - 1)) : '0;
      e1 = (c >= 1 && c <= 16) ? oh(4'(16 - c)) : '0;
      checks++;
      if (RWL0 !== e0 || RWL1 !== e1) begin
        errors++;
        $display("FAIL b2b_rwl c=%0d: got %h %h required %h %h", c, RWL0, RWL1, e0, e1);
      end
      checks++;
      if (bus.rd0_vld !== (c >= 2 && c <= 17) || bus.rd1_vld !== (c >= 2 && c <= 17)) begin
        errors++;
        $display("FAIL b2b_vld c=%0d: got %b%b", c, bus.rd0_vld, bus.rd1_vld);
      end
      if (c >= 2 && c <= 17) begin
        checks++;
        if (bus.rd0_data !== pat(4'(c - 2)) || bus.rd1_data !== pat(4'(17 - c))) begin
          errors++;
          $display("FAIL b2b_data c=%0d: got %h %h required %h %h", c, bus.rd0_data,
                   bus.rd1_data, pat(4'(c - 2)), pat(4'(17 - c)));
        end
      end
      if (bus.rd0_vld) n0++;
      if (bus.rd1_vld) n1++;
      tick();
    end
    checks++;
    if (n0 != 16 || n1 != 16) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d %0d required 16 16", n0, n1);
    end
  endtask

  task automatic test_same_cycle();
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    do_write(4'd3, 12'h111);
    bus.wr_req = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 12'h222;
    bus.rd0_req = 1'b1; bus.rd0_addr = 4'd3;
    #1;
    checks++;
    if ({bus.wr_ack, bus.rd0_ack} !== 2'b11) begin
      errors++;
      $display("FAIL same_cycle_acks: got %b%b required 11", bus.wr_ack, bus.rd0_ack);
    end
    tick();
    bus.wr_req = 1'b0;
    bus.rd0_req = 1'b0;
    shadow[3] = 12'h222;
    tick();
    checks++;
    if (bus.rd0_vld !== 1'b1 || bus.rd0_data !== 12'h111) begin
      errors++;
      $display("FAIL same_cycle_old: got vld=%b data=%h required 1 111", bus.rd0_vld, bus.rd0_data);
    end
    tick();
    tick();
    do_read(0, 4'd3, st, rwl, vld, dat);
    checks++;
    if (vld !== 1'b1 || dat !== 12'h222) begin
      errors++;
      $display("FAIL same_cycle_new: got vld=%b data=%h required 1 222", vld, dat);
    end
  endtask

  task automatic test_conflict();
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    int exp_st; logic [0:15] exp_rwl;
`ifdef TOYSRAM_CTL_WR_BYPASS_EN
    exp_st = 0;
    exp_rwl = '0;
`else
    exp_st = 3;
    exp_rwl = oh(4'd7);
`endif
    do_write(4'd7, 12'h0F0);
    bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 12'hF0F;
    tick();
    bus.wr_req = 1'b0;
    shadow[7] = 12'hF0F;
    do_read(0, 4'd7, st, rwl, vld, dat);
    checks++;
    if (st != exp_st) begin errors++; $display("FAIL conflict_stall: got %0d required %0d", st, exp_st); end
    checks++;
    if (rwl !== exp_rwl) begin errors++; $display("FAIL conflict_rwl: got %h required %h", rwl, exp_rwl); end
    checks++;
    if (vld !== 1'b1 || dat !== 12'hF0F) begin
      errors++;
      $display("FAIL conflict_data: got vld=%b data=%h required 1 f0f", vld, dat);
    end
    tick(); tick(); tick();
    do_read(0, 4'd7, st, rwl, vld, dat);
    checks++;
    if (dat !== 12'hF0F) begin errors++; $display("FAIL conflict_array: got %h required f0f", dat); end
  endtask

  task automatic test_no_stall();
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 12'h3C3;
    tick();
    bus.wr_req = 1'b0;
    shadow[9] = 12'h3C3;
    do_read(1, 4'd5, st, rwl, vld, dat);
    checks++;
    if (st != 0 || rwl !== oh(4'd5)) begin
      errors++;
      $display("FAIL no_stall: got stalls=%0d rwl=%h required 0 %h", st, rwl, oh(4'd5));
    end
    checks++;
    if (vld !== 1'b1 || dat !== shadow[5]) begin
      errors++;
      $display("FAIL no_stall_data: got vld=%b data=%h required 1 %h", vld, dat, shadow[5]);
    end
    tick(); tick(); tick();
    do_read(0, 4'd9, st, rwl, vld, dat);
    checks++;
    if (dat !== 12'h3C3) begin errors++; $display("FAIL no_stall_write: got %h required 3c3", dat); end
  endtask

  task automatic test_write_stream();
    int acks, pulses;
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    logic [0:15] ew;
    acks = 0;
    pulses = 0;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 12'h5A5;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (bus.wr_ack !== (k % 4 == 0) || bus.wr_busy !== (k % 4 != 0)) begin
        errors++;
        $display("FAIL stream_ack k=%0d: got ack=%b busy=%b", k, bus.wr_ack, bus.wr_busy);
      end
      ew = (k % 4 == 2) ? oh(4'd1) : '0;
      checks++;
      if (WWL !== ew) begin errors++; $display("FAIL stream_wwl k=%0d: got %h required %h", k, WWL, ew); end
      if (WWL !== '0) begin
        checks++;
        if (WBL !== 12'h5A5 || WBLb !== ~WBL) begin
          errors++;
          $display("FAIL stream_bitlines k=%0d: got %h %h required 5a5 a5a", k, WBL, WBLb);
        end
        pulses++;
      end
      if (bus.wr_ack) acks++;
      tick();
    end
    bus.wr_req = 1'b0;
    shadow[1] = 12'h5A5;
    checks++;
    if (acks != 4 || pulses != 4) begin
      errors++;
      $display("FAIL stream_counts: got acks=%0d pulses=%0d required 4 4", acks, pulses);
    end
    do_read(0, 4'd1, st, rwl, vld, dat);
    checks++;
    if (dat !== 12'h5A5) begin errors++; $display("FAIL stream_data: got %h required 5a5", dat); end
  endtask

  task automatic test_reset_mid_write();
    int st; logic [0:15] rwl; logic vld; logic [0:11] dat;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd11; bus.wr_data = 12'h7E7;
    tick();
    bus.wr_req = 1'b0;
    bus.rd1_req = 1'b1; bus.rd1_addr = 4'd0;
    tick();
    bus.rd1_req = 1'b0;
    #1;
    checks++;
    if (WWL !== oh(4'd11) || RWL1 !== oh(4'd0)) begin
      errors++;
      $display("FAIL midrst_pre: got wwl=%h rwl1=%h required %h %h", WWL, RWL1, oh(4'd11), oh(4'd0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({WWL, RWL0, RWL1} !== '0 || {WBL, WBLb} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got wwl=%h rwl=%h %h wbl=%h %h required 0", WWL, RWL0, RWL1, WBL, WBLb);
    end
    checks++;
    if (bus.wr_busy !== 1'b0 || {bus.rd0_vld, bus.rd1_vld} !== 2'b00 ||
        {bus.rd0_data, bus.rd1_data} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b vld=%b%b data=%h %h required 0", bus.wr_busy,
               bus.rd0_vld, bus.rd1_vld, bus.rd0_data, bus.rd1_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.rd1_vld !== 1'b0 || bus.wr_busy !== 1'b0 || WWL !== '0) begin
        errors++;
        $display("FAIL midrst_replay k=%0d: got vld=%b busy=%b wwl=%h required 0", k, bus.rd1_vld,
                 bus.wr_busy, WWL);
      end
    end
    do_write(4'd11, 12'h0AA);
    do_read(1, 4'd11, st, rwl, vld, dat);
    checks++;
    if (vld !== 1'b1 || dat !== 12'h0AA) begin
      errors++;
      $display("FAIL midrst_recover: got vld=%b data=%h required 1 0aa", vld, dat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rd0_req = 1'b0; bus.rd0_addr = '0;
    bus.rd1_req = 1'b0; bus.rd1_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_same_cycle();
    test_conflict();
    test_no_stall();
    test_write_stream();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
